// File: rtl/multicycle_control_if.sv
// Bundle of instruction fields, memory handshakes and control strobes that run
// between the multicycle controller and the datapath/memory side.
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    // Instruction register fields
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;

    // Memory handshakes
    logic             imem_req;
    logic             imem_ack;
    logic             dmem_req;
    logic             dmem_ack;

    // Datapath strobes
    logic             ir_ld;
    logic             pc_wr;
    logic             RuWr;
    logic             DMWr;

    // Datapath selects, latched once per instruction
    logic             AluASrc;
    logic             AluBSrc;
    logic [2:0]       ImmSrc;
    logic [3:0]       ALUOp;
    logic [4:0]       BrOp;
    logic [2:0]       DMCtrl;
    logic [1:0]       RUDataWrSrc;

    // Status
    logic [CNT_W-1:0] retired;
    logic             trap;
    logic [1:0]       trap_cause;

    // Datapath / memory side
    modport master (
        output opcode, funct3, funct7, imem_ack, dmem_ack,
        input  imem_req, dmem_req, ir_ld, pc_wr, RuWr, DMWr,
               AluASrc, AluBSrc, ImmSrc, ALUOp, BrOp, DMCtrl, RUDataWrSrc,
               retired, trap, trap_cause
    );

    // Controller side
    modport slave (
        input  opcode, funct3, funct7, imem_ack, dmem_ack,
        output imem_req, dmem_req, ir_ld, pc_wr, RuWr, DMWr,
               AluASrc, AluBSrc, ImmSrc, ALUOp, BrOp, DMCtrl, RUDataWrSrc,
               retired, trap, trap_cause
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RV32I control unit: FETCH -> DECODE -> EXEC -> (MEM) -> WB with
// handshake timeouts, illegal-instruction detection, a sticky trap state and a
// retired-instruction counter. Datapath selects are decoded from the
// instruction register and latched on the DECODE->EXEC transition.
module multicycle_control #(
    parameter int TIMEOUT  = 15,
    parameter int CNT_W    = 32,
    parameter bit EN_UTYPE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.slave  bus
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_S     = 3'b001;
    localparam logic [2:0] IMM_U     = 3'b010;
    localparam logic [2:0] IMM_B     = 3'b101;
    localparam logic [2:0] IMM_J     = 3'b110;

    localparam logic [1:0] WR_ALU    = 2'b00;
    localparam logic [1:0] WR_DM     = 2'b01;
    localparam logic [1:0] WR_PC4    = 2'b10;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Wait counter only needs to reach TIMEOUT-1: the TIMEOUT-th idle cycle traps
    localparam int              WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    state_t            state_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [CNT_W-1:0]  retired_reg;
    logic              trap_reg;
    logic [1:0]        trap_cause_reg;

    logic              imem_req_reg;
    logic              dmem_req_reg;
    logic              pc_wr_reg;
    logic              ru_wr_reg;
    logic              dm_wr_reg;

    logic              alu_a_src_reg;
    logic              alu_b_src_reg;
    logic [2:0]        imm_src_reg;
    logic [3:0]        alu_op_reg;
    logic [4:0]        br_op_reg;
    logic [2:0]        dm_ctrl_reg;
    logic [1:0]        wr_src_reg;

    // Per-instruction sequencing flags captured alongside the selects
    logic              mem_op_reg;
    logic              store_op_reg;
    logic              wb_write_reg;

    logic              dec_legal;
    logic              dec_a_src;
    logic              dec_b_src;
    logic [2:0]        dec_imm_src;
    logic [3:0]        dec_alu_op;
    logic [4:0]        dec_br_op;
    logic [2:0]        dec_dm_ctrl;
    logic [1:0]        dec_wr_src;
    logic              dec_wb_write;
    logic              dec_mem_op;
    logic              dec_store_op;

    logic              fetch_done;

    // Instruction decode of the current IR fields into selects and legality
    always_comb begin
        dec_legal    = 1'b0;
        dec_a_src    = 1'b0;
        dec_b_src    = 1'b0;
        dec_imm_src  = IMM_I;
        dec_alu_op   = 4'b0000;
        dec_br_op    = 5'b00000;
        dec_dm_ctrl  = 3'b000;
        dec_wr_src   = WR_ALU;
        dec_wb_write = 1'b0;
        dec_mem_op   = 1'b0;
        dec_store_op = 1'b0;
        case (bus.opcode)
            OP_R: begin
                dec_wb_write = 1'b1;
                dec_alu_op   = {bus.funct7[5], bus.funct3};
                dec_legal    = (bus.funct7 == F7_ZERO) ||
                               ((bus.funct7 == F7_ALT) &&
                                ((bus.funct3 == 3'b000) || (bus.funct3 == 3'b101)));
            end
            OP_I: begin
                dec_b_src    = 1'b1;
                dec_wb_write = 1'b1;
                dec_alu_op   = {(bus.funct3 == 3'b101) ? bus.funct7[5] : 1'b0, bus.funct3};
                case (bus.funct3)
                    3'b001:  dec_legal = (bus.funct7 == F7_ZERO);
                    3'b101:  dec_legal = (bus.funct7 == F7_ZERO) || (bus.funct7 == F7_ALT);
                    default: dec_legal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                dec_b_src    = 1'b1;
                dec_wb_write = 1'b1;
                dec_mem_op   = 1'b1;
                dec_dm_ctrl  = bus.funct3;
                dec_wr_src   = WR_DM;
                dec_legal    = !(bus.funct3 inside {3'b011, 3'b110, 3'b111});
            end
            OP_STORE: begin
                dec_b_src    = 1'b1;
                dec_imm_src  = IMM_S;
                dec_mem_op   = 1'b1;
                dec_store_op = 1'b1;
                dec_dm_ctrl  = bus.funct3;
                dec_legal    = (bus.funct3 <= 3'b010);
            end
            OP_BRANCH: begin
                dec_a_src    = 1'b1;
                dec_b_src    = 1'b1;
                dec_imm_src  = IMM_B;
                dec_br_op    = {2'b01, bus.funct3};
                dec_legal    = !(bus.funct3 inside {3'b010, 3'b011});
            end
            OP_JAL: begin
                dec_a_src    = 1'b1;
                dec_b_src    = 1'b1;
                dec_imm_src  = IMM_J;
                dec_br_op    = 5'b10000;
                dec_wr_src   = WR_PC4;
                dec_wb_write = 1'b1;
                dec_legal    = 1'b1;
            end
            OP_JALR: begin
                dec_b_src    = 1'b1;
                dec_imm_src  = IMM_I;
                dec_br_op    = 5'b10000;
                dec_wr_src   = WR_PC4;
                dec_wb_write = 1'b1;
                dec_legal    = (bus.funct3 == 3'b000);
            end
            OP_LUI: begin
                dec_b_src    = 1'b1;
                dec_imm_src  = IMM_U;
                dec_alu_op   = 4'b1111;
                dec_wb_write = 1'b1;
                dec_legal    = EN_UTYPE;
            end
            OP_AUIPC: begin
                dec_a_src    = 1'b1;
                dec_b_src    = 1'b1;
                dec_imm_src  = IMM_U;
                dec_wb_write = 1'b1;
                dec_legal    = EN_UTYPE;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // A fetch completes only while the request is actually being presented
    assign fetch_done = (state_reg == FETCH) && imem_req_reg && bus.imem_ack;

    // Control FSM with registered strobes, latched selects and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= FETCH;
            wait_cnt_reg   <= '0;
            retired_reg    <= '0;
            trap_reg       <= 1'b0;
            trap_cause_reg <= 2'b00;
            imem_req_reg   <= 1'b0;
            dmem_req_reg   <= 1'b0;
            pc_wr_reg      <= 1'b0;
            ru_wr_reg      <= 1'b0;
            dm_wr_reg      <= 1'b0;
            alu_a_src_reg  <= 1'b0;
            alu_b_src_reg  <= 1'b0;
            imm_src_reg    <= 3'b000;
            alu_op_reg     <= 4'b0000;
            br_op_reg      <= 5'b00000;
            dm_ctrl_reg    <= 3'b000;
            wr_src_reg     <= 2'b00;
            mem_op_reg     <= 1'b0;
            store_op_reg   <= 1'b0;
            wb_write_reg   <= 1'b0;
        end else begin
            case (state_reg)
                FETCH: begin
                    imem_req_reg <= 1'b1;
                    if (fetch_done) begin
                        // Ack wins even on the cycle the counter would expire
                        imem_req_reg <= 1'b0;
                        wait_cnt_reg <= '0;
                        state_reg    <= DECODE;
                    end else if (imem_req_reg) begin
                        if (wait_cnt_reg == WAIT_LAST) begin
                            imem_req_reg   <= 1'b0;
                            wait_cnt_reg   <= '0;
                            trap_reg       <= 1'b1;
                            trap_cause_reg <= CAUSE_TIMEOUT;
                            state_reg      <= TRAP;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                        end
                    end
                end
                DECODE: begin
                    if (!dec_legal) begin
                        trap_reg       <= 1'b1;
                        trap_cause_reg <= CAUSE_ILLEGAL;
                        state_reg      <= TRAP;
                    end else begin
                        alu_a_src_reg <= dec_a_src;
                        alu_b_src_reg <= dec_b_src;
                        imm_src_reg   <= dec_imm_src;
                        alu_op_reg    <= dec_alu_op;
                        br_op_reg     <= dec_br_op;
                        dm_ctrl_reg   <= dec_dm_ctrl;
                        wr_src_reg    <= dec_wr_src;
                        mem_op_reg    <= dec_mem_op;
                        store_op_reg  <= dec_store_op;
                        wb_write_reg  <= dec_wb_write;
                        state_reg     <= EXEC;
                    end
                end
                EXEC: begin
                    if (mem_op_reg) begin
                        dmem_req_reg <= 1'b1;
                        dm_wr_reg    <= store_op_reg;
                        state_reg    <= MEM;
                    end else begin
                        pc_wr_reg <= 1'b1;
                        ru_wr_reg <= wb_write_reg;
                        state_reg <= WB;
                    end
                end
                MEM: begin
                    if (bus.dmem_ack) begin
                        dmem_req_reg <= 1'b0;
                        dm_wr_reg    <= 1'b0;
                        wait_cnt_reg <= '0;
                        pc_wr_reg    <= 1'b1;
                        ru_wr_reg    <= wb_write_reg;
                        state_reg    <= WB;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        dmem_req_reg   <= 1'b0;
                        dm_wr_reg      <= 1'b0;
                        wait_cnt_reg   <= '0;
                        trap_reg       <= 1'b1;
                        trap_cause_reg <= CAUSE_TIMEOUT;
                        state_reg      <= TRAP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                    end
                end
                WB: begin
                    pc_wr_reg    <= 1'b0;
                    ru_wr_reg    <= 1'b0;
                    retired_reg  <= retired_reg + CNT_W'(1);
                    imem_req_reg <= 1'b1;
                    state_reg    <= FETCH;
                end
                TRAP: begin
                    // Sticky until reset; every strobe stays low
                    imem_req_reg <= 1'b0;
                    dmem_req_reg <= 1'b0;
                    pc_wr_reg    <= 1'b0;
                    ru_wr_reg    <= 1'b0;
                    dm_wr_reg    <= 1'b0;
                end
                default: begin
                    state_reg <= TRAP;
                end
            endcase
        end
    end

    assign bus.imem_req    = imem_req_reg;
    assign bus.dmem_req    = dmem_req_reg;
    assign bus.ir_ld       = fetch_done;
    assign bus.pc_wr       = pc_wr_reg;
    assign bus.RuWr        = ru_wr_reg;
    assign bus.DMWr        = dm_wr_reg;
    assign bus.AluASrc     = alu_a_src_reg;
    assign bus.AluBSrc     = alu_b_src_reg;
    assign bus.ImmSrc      = imm_src_reg;
    assign bus.ALUOp       = alu_op_reg;
    assign bus.BrOp        = br_op_reg;
    assign bus.DMCtrl      = dm_ctrl_reg;
    assign bus.RUDataWrSrc = wr_src_reg;
    assign bus.retired     = retired_reg;
    assign bus.trap        = trap_reg;
    assign bus.trap_cause  = trap_cause_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed instructions, timeouts,
// reset mid-MEM and a randomized instruction stream, all judged against a
// cycle-level behavioural model of the instruction lifecycle.
module tb_multicycle_control;

    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic       legal;
        logic       a;
        logic       b;
        logic [2:0] imm;
        logic [3:0] aluop;
        logic [4:0] brop;
        logic [2:0] dmc;
        logic [1:0] wsrc;
        logic       ruwr;
        logic       mem;
        logic       st;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int   n_assert    = 0;
    int   n_fail      = 0;
    int   exp_retired = 0;
    exp_t prev_ctl    = '0;

    multicycle_control_if #(.CNT_W(CNT_W)) bus ();

    multicycle_control #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W),
        .EN_UTYPE(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] strobes();
        return {bus.imem_req, bus.dmem_req, bus.ir_ld, bus.pc_wr, bus.RuWr, bus.DMWr};
    endfunction

    function automatic logic [18:0] latched_obs();
        return {bus.AluASrc, bus.AluBSrc, bus.ImmSrc, bus.ALUOp, bus.BrOp, bus.DMCtrl, bus.RUDataWrSrc};
    endfunction

    function automatic logic [18:0] latched_exp(input exp_t e);
        return {e.a, e.b, e.imm, e.aluop, e.brop, e.dmc, e.wsrc};
    endfunction

    function automatic logic [31:0] all_outputs();
        return {strobes(), latched_obs(), bus.retired, bus.trap, bus.trap_cause};
    endfunction

    // What an instruction should do, by instruction class
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        exp_t       e;
        logic [7:0] ok3;
        e = '0;
        ok3 = 8'hFF;
        case (op)
            OP_R: begin
                e.legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                e.aluop = {f7[5], f3};
                e.ruwr  = 1'b1;
            end
            OP_I: begin
                if (f3 == 3'd1)      e.legal = (f7 == 7'h00);
                else if (f3 == 3'd5) e.legal = (f7 == 7'h00) || (f7 == 7'h20);
                else                 e.legal = 1'b1;
                e.b     = 1'b1;
                e.aluop = (f3 == 3'd5) ? {f7[5], f3} : {1'b0, f3};
                e.ruwr  = 1'b1;
            end
            OP_LOAD: begin
                ok3 = 8'b0011_0111;
                e.legal = ok3[f3];
                e.b = 1'b1; e.dmc = f3; e.wsrc = 2'b01; e.ruwr = 1'b1; e.mem = 1'b1;
            end
            OP_STORE: begin
                ok3 = 8'b0000_0111;
                e.legal = ok3[f3];
                e.b = 1'b1; e.imm = 3'b001; e.dmc = f3; e.mem = 1'b1; e.st = 1'b1;
            end
            OP_BRANCH: begin
                ok3 = 8'b1111_0011;
                e.legal = ok3[f3];
                e.a = 1'b1; e.b = 1'b1; e.imm = 3'b101; e.brop = {2'b01, f3};
            end
            OP_JAL: begin
                e.legal = 1'b1;
                e.a = 1'b1; e.b = 1'b1; e.imm = 3'b110; e.brop = 5'b10000; e.wsrc = 2'b10; e.ruwr = 1'b1;
            end
            OP_JALR: begin
                e.legal = (f3 == 3'd0);
                e.b = 1'b1; e.brop = 5'b10000; e.wsrc = 2'b10; e.ruwr = 1'b1;
            end
            OP_LUI: begin
                e.legal = 1'b1;
                e.b = 1'b1; e.imm = 3'b010; e.aluop = 4'b1111; e.ruwr = 1'b1;
            end
            OP_AUIPC: begin
                e.legal = 1'b1;
                e.a = 1'b1; e.b = 1'b1; e.imm = 3'b010; e.ruwr = 1'b1;
            end
            default: e.legal = 1'b0;
        endcase
        return e;
    endfunction

    // Reset pulse; leaves the bench 3 time units after the first edge with rst_n high
    task automatic do_reset();
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        check("reset_outputs", all_outputs(), 32'h0);
        @(posedge clk); #2;
        check("reset_held", all_outputs(), 32'h0);
        rst_n = 1'b1;
        #1;
        check("post_reset_pre_edge_req", strobes(), 6'b000000);
        @(posedge clk); #3;
        check("post_reset_first_edge_req", strobes(), 6'b100000);
        check("post_reset_trap", {bus.trap, bus.trap_cause}, 3'b000);
        exp_retired = 0;
        prev_ctl = '0;
    endtask

    // Trap must persist with all strobes low, even while acks are offered
    task automatic check_trap(input logic [1:0] cause, input string tag);
        for (int i = 0; i < 3; i++) begin
            bus.imem_ack = i[0];
            bus.dmem_ack = ~i[0];
            #1;
            check({tag, "_trap"}, {bus.trap, bus.trap_cause}, {1'b1, cause});
            check({tag, "_strobes"}, strobes(), 6'b000000);
            check({tag, "_retired"}, bus.retired, exp_retired[CNT_W-1:0]);
            @(posedge clk); #2;
        end
        do_reset();
    endtask

    // One instruction: df/dm are fetch/data ack delays in cycles, rst_mem is the
    // MEM cycle at which reset is forced (-1 for none)
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input int df, input int dm, input int rst_mem);
        exp_t e;
        e = model(op, f3, f7);
        $display("instr op=%b f3=%b f7=%b df=%0d dm=%0d legal=%0d retired_before=%0d",
                 op, f3, f7, df, dm, e.legal, exp_retired);
        bus.opcode = op;
        bus.funct3 = f3;
        bus.funct7 = f7;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        // FETCH
        for (int i = 0; i < ((df >= TIMEOUT) ? TIMEOUT : df); i++) begin
            #1;
            check("fetch_wait_strobes", strobes(), 6'b100000);
            check("fetch_wait_trap", bus.trap, 1'b0);
            @(posedge clk); #2;
        end
        if (df >= TIMEOUT) begin
            check_trap(2'b10, "fetch_timeout");
            return;
        end
        bus.imem_ack = 1'b1;
        #1;
        check("fetch_ack_strobes", strobes(), 6'b101000);
        @(posedge clk); #2;
        bus.imem_ack = 1'b0;
        // DECODE
        #1;
        check("decode_strobes", strobes(), 6'b000000);
        check("decode_hold_prev", latched_obs(), latched_exp(prev_ctl));
        check("decode_retired", bus.retired, exp_retired[CNT_W-1:0]);
        @(posedge clk); #2;
        if (!e.legal) begin
            check_trap(2'b01, "illegal");
            return;
        end
        // EXEC
        #1;
        check("exec_strobes", strobes(), 6'b000000);
        check("exec_ctl", latched_obs(), latched_exp(e));
        prev_ctl = e;
        @(posedge clk); #2;
        // MEM
        if (e.mem) begin
            for (int i = 0; i <= ((dm >= TIMEOUT) ? TIMEOUT - 1 : dm); i++) begin
                if (i == dm) bus.dmem_ack = 1'b1;
                #1;
                check("mem_strobes", strobes(), {4'b0100, 1'b0, e.st});
                check("mem_ctl", latched_obs(), latched_exp(e));
                if (i == rst_mem) begin
                    rst_n = 1'b0;
                    #1;
                    check("reset_mid_mem", all_outputs(), 32'h0);
                    do_reset();
                    return;
                end
                @(posedge clk); #2;
            end
            bus.dmem_ack = 1'b0;
            if (dm >= TIMEOUT) begin
                check_trap(2'b10, "mem_timeout");
                return;
            end
        end
        // WB
        #1;
        check("wb_strobes", strobes(), {4'b0001, e.ruwr, 1'b0});
        check("wb_ctl", latched_obs(), latched_exp(e));
        check("wb_retired", bus.retired, exp_retired[CNT_W-1:0]);
        @(posedge clk); #2;
        exp_retired = (exp_retired + 1) % (1 << CNT_W);
        #1;
        check("next_fetch_strobes", strobes(), 6'b100000);
        check("retired_count", bus.retired, exp_retired[CNT_W-1:0]);
    endtask

    logic [6:0] op_pool [12];
    logic [6:0] rop;
    logic [2:0] rf3;
    logic [6:0] rf7;
    int         sel;
    int         rdf;
    int         rdm;

    initial begin
        bus.opcode   = 7'h0;
        bus.funct3   = 3'h0;
        bus.funct7   = 7'h0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        #2;
        do_reset();

        // Directed instructions
        run_instr(OP_R,      3'b000, 7'h00, 0, 0, -1);  // add
        run_instr(OP_LOAD,   3'b010, 7'h00, 0, 3, -1);  // lw, data ack delayed 3
        run_instr(OP_STORE,  3'b010, 7'h00, 1, 0, -1);  // sw
        run_instr(OP_BRANCH, 3'b000, 7'h00, 0, 0, -1);  // beq
        run_instr(OP_JAL,    3'b000, 7'h00, 0, 0, -1);  // jal
        run_instr(OP_JALR,   3'b000, 7'h00, 2, 0, -1);  // jalr
        run_instr(OP_LUI,    3'b101, 7'h55, 0, 0, -1);  // lui
        run_instr(OP_AUIPC,  3'b011, 7'h12, 0, 0, -1);  // auipc
        run_instr(OP_R,      3'b000, 7'h20, 0, 0, -1);  // sub
        run_instr(OP_I,      3'b101, 7'h20, 0, 0, -1);  // srai
        run_instr(OP_I,      3'b001, 7'h00, 0, 0, -1);  // slli
        run_instr(OP_R,      3'b000, 7'h01, 0, 0, -1);  // illegal funct7
        run_instr(OP_LOAD,   3'b011, 7'h00, 0, 0, -1);  // illegal load width
        run_instr(OP_BRANCH, 3'b010, 7'h00, 0, 0, -1);  // illegal branch
        run_instr(7'b1110011, 3'b000, 7'h00, 0, 0, -1); // unsupported opcode

        // Fetch ack arriving on the last permitted cycle is still accepted
        run_instr(OP_R,      3'b111, 7'h00, TIMEOUT - 1, 0, -1);
        // Fetch ack never arrives
        run_instr(OP_R,      3'b000, 7'h00, TIMEOUT, 0, -1);
        // Data ack arriving on the last permitted cycle, then never arriving
        run_instr(OP_LOAD,   3'b100, 7'h00, 0, TIMEOUT - 1, -1);
        run_instr(OP_STORE,  3'b000, 7'h00, 0, TIMEOUT, -1);

        // Reset in the middle of a store's MEM phase
        run_instr(OP_R,      3'b000, 7'h00, 0, 0, -1);
        run_instr(OP_STORE,  3'b001, 7'h00, 0, 5, 2);

        // Enough back-to-back instructions to wrap the retired counter
        for (int k = 0; k < (1 << CNT_W) + 2; k++) begin
            run_instr(OP_I, 3'b000, 7'h3F, 0, 0, -1);
        end

        // Randomized instruction stream
        op_pool = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL,
                    OP_JALR, OP_LUI, OP_AUIPC, OP_R, OP_I, 7'b0001111};
        for (int k = 0; k < 60; k++) begin
            sel = $urandom_range(0, 12);
            rop = (sel == 12) ? 7'($urandom) : op_pool[sel];
            rf3 = 3'($urandom);
            case ($urandom_range(0, 3))
                0, 1:    rf7 = 7'h00;
                2:       rf7 = 7'h20;
                default: rf7 = 7'($urandom);
            endcase
            rdf = ($urandom_range(0, 14) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT) : $urandom_range(0, 3);
            rdm = ($urandom_range(0, 14) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT) : $urandom_range(0, 3);
            run_instr(rop, rf3, rf7, rdf, rdm, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum wait cycles for imem_ack/dmem_ack before trap.
REQ-002 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 Parameter EN_UTYPE, default 1: 1 = LUI/AUIPC legal; 0 = decoded as illegal.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset is asynchronous and active-low.
REQ-006 opcode/funct3/funct7  in  7/3/7  fields of the instruction register.
REQ-007 imem_req  out  1 / imem_ack  in  1  instruction-fetch handshake.
REQ-008 dmem_req  out  1 / dmem_ack  in  1  data-memory handshake.
REQ-009 ir_ld  out  1  load instruction register; pc_wr  out  1  update PC.
REQ-010 AluASrc, AluBSrc, RuWr, DMWr  out  1 each; ImmSrc  out  3; ALUOp  out  4; BrOp  out  5; DMCtrl  out  3; RUDataWrSrc  out  2.
REQ-011 retired  out  CNT_W  count of completed instructions; trap  out  1; trap_cause  out  2 (01 illegal, 10 timeout).

Function
REQ-012 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-013 FETCH: imem_req=1; when imem_ack=1, ir_ld=1 in that cycle -> DECODE. Ack in the same cycle as req is legal.
REQ-014 DECODE: 1 cycle; illegal -> TRAP with cause 01; otherwise latch control outputs -> EXEC.
REQ-015 EXEC: 1 cycle; load/store -> MEM; all others -> WB.
REQ-016 MEM: dmem_req=1; DMWr=1 only for stores, only in MEM; on dmem_ack -> WB.
REQ-017 WB: pc_wr=1; RuWr=1 for all types except store/branch; retired increments by 1 -> FETCH.
REQ-018 TRAP: sticky until rst_n; all strobes (imem_req, dmem_req, ir_ld, pc_wr, RuWr, DMWr) held 0.
REQ-019 Wait counter increments each cycle in FETCH/MEM without ack, clears on ack or state change. Reaching TIMEOUT -> TRAP with cause 10; ack on that same cycle wins.
REQ-020 Zero-wait latency SHALL be 4 cycles (FETCH->WB) for R/I/branch/jump/U-type, and 5 cycles for load/store.
REQ-021 Latched outputs (AluASrc, AluBSrc, ImmSrc, ALUOp, BrOp, DMCtrl, RUDataWrSrc) change only on the DECODE->EXEC transition and hold through WB.
REQ-022 Encodings: AluASrc 1=PC; AluBSrc 1=imm; ImmSrc I=000 S=001 U=010 B=101 J=110; RUDataWrSrc 00 ALU, 01 DM, 10 PC+4.
REQ-023 ALUOp: R-type {funct7[5],funct3}; I-type {funct3==101 ? funct7[5] : 0, funct3}; load/store/JAL/JALR/AUIPC 0000; LUI 1111 (pass B).
REQ-024 BrOp: 00000 none; branch {2'b01,funct3}; JAL/JALR 10000. DMCtrl = funct3 for load/store, else 000.
REQ-025 Illegal cases:
  - unsupported opcode;
  - R-type funct7 not 0000000/0100000, or 0100000 with funct3 not 000/101;
  - shift-immediate funct7 not 0000000 (or 0100000 for funct3=101);
  - load funct3 011/110/111;
  - store funct3 >010;
  - branch funct3 010/011;
  - JALR funct3 != 000.
REQ-026 retired SHALL wrap from 2^CNT_W-1 to 0.

Reset
REQ-027 rst_n low SHALL immediately force FETCH, clear the wait counter, retired, trap, and trap_cause, and drive all outputs to 0.
REQ-028 Reset mid-MEM SHALL drop dmem_req and DMWr asynchronously; the interrupted instruction is not counted.
REQ-029 After rst_n rises, imem_req=1 on the first clock edge.

Verification
REQ-030 add (0110011/000/0000000), acks immediate -> EXEC shows ALUOp=0000; WB shows RuWr=1, pc_wr=1; retired=1 after 4 cycles.
REQ-031 lw (0000011/010) with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, RUDataWrSrc=01, DMCtrl=010, RuWr=1 only in WB.
REQ-032 sw (0100011/010) -> DMWr=1 only in MEM, ImmSrc=001, RuWr=0 in WB.
REQ-033 beq and jal -> BrOp=01000 / 10000; jal shows RUDataWrSrc=10, ImmSrc=110.
REQ-034 opcode 0110011 with funct7=0000001, or load funct3=011 -> TRAP, trap_cause=01, no pc_wr, state sticky until reset.
REQ-035 imem_ack held low for 15 cycles -> trap, trap_cause=10; reset asserted mid-MEM -> all outputs 0 in the same cycle.
